data_mem_responder: RTL and testbench

Word-access data memory that answers load/store requests from the processor datapath over a req/ack handshake. It replaces the processor's zero-latency combinational data-memory read with a wait-stated responder. Storage is byte-organised and big-endian, matching the processor's `datmem` layout: byte at `a` is bits 31:24, `a+3` is bits 7:0. It adds a configurable access latency and a misalignment error response, so multi-cycle and stall-capable processor variants can be built against it.

---
 rtl/data_mem_responder.sv | 148 ++++++++++++++
 tb/tb_data_mem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Byte-organised big-endian word memory with req/ack handshake,
//            configurable wait states and misaligned-access error response.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int ADDR_BITS   = 5,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int             c_DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0]     c_WAIT  = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [3:0]           r_cnt;
  logic                 r_we;
  logic [ADDR_BITS-1:0] r_addr;
  logic [31:0]          r_wdata;
  logic [7:0]           r_mem [c_DEPTH];
  logic [31:0]          r_rdata;
  logic                 r_ack;
  logic                 r_err;
  logic                 r_busy;

  logic                 w_accept;
  logic                 w_commit;
  logic                 w_misaligned;
  logic                 w_store;
  logic                 w_load;
  logic                 w_ack_d;
  logic                 w_err_d;
  logic                 w_busy_d;
  logic [ADDR_BITS-1:0] w_a0;
  logic [ADDR_BITS-1:0] w_a1;
  logic [ADDR_BITS-1:0] w_a2;
  logic [ADDR_BITS-1:0] w_a3;
  logic                 w_unused_addr;

  // Upper address bits are deliberately ignored.
  assign w_unused_addr = &{1'b0, addr[31:ADDR_BITS]};

  assign w_accept     = (r_state == S_IDLE) && req;
  assign w_commit     = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_misaligned = (r_addr[1:0] != 2'b00);
  assign w_store      = w_commit && r_we && !w_misaligned;
  assign w_load       = w_commit && !r_we && !w_misaligned;

  // Byte lanes wrap modulo the storage depth.
  assign w_a0 = r_addr;
  assign w_a1 = r_addr + ADDR_BITS'(1);
  assign w_a2 = r_addr + ADDR_BITS'(2);
  assign w_a3 = r_addr + ADDR_BITS'(3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (req) w_next_state = S_WAIT;
      S_WAIT: if (r_cnt == 4'd0) w_next_state = S_RESP;
      S_RESP: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered on the same edge.
  always_comb begin
    w_ack_d  = (w_next_state == S_RESP);
    w_err_d  = w_ack_d && w_misaligned;
    w_busy_d = (w_next_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_cnt   <= c_WAIT;
      r_we    <= we;
      r_addr  <= addr[ADDR_BITS-1:0];
      r_wdata <= wdata;
    end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= 8'd0;
      end
    end else if (w_store) begin
      r_mem[w_a0] <= r_wdata[31:24];
      r_mem[w_a1] <= r_wdata[23:16];
      r_mem[w_a2] <= r_wdata[15:8];
      r_mem[w_a3] <= r_wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      if (w_load) begin
        r_rdata <= {r_mem[w_a0], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};
      end
      r_ack  <= w_ack_d;
      r_err  <= w_err_d;
      r_busy <= w_busy_d;
    end
  end

  assign rdata = r_rdata;
  assign ack   = r_ack;
  assign err   = r_err;
  assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Directed self-checking bench for data_mem_responder (W=2 and W=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        req, we;
  logic [31:0] addr, wdata, rdata;
  logic        ack, err, busy;
  logic        req0, we0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        ack0, err0, busy0;

  int checks   = 0;
  int failures = 0;

  data_mem_responder #(.ADDR_BITS(5), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
  );

  data_mem_responder #(.ADDR_BITS(5), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .addr(addr0),
    .wdata(wdata0), .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction on the W=2 instance; req held until ack.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e, output int lat);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    lat = 0;
    while (!ack && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    req = 1'b0;
    if (lat >= 20) check("ack_timeout", 32'(lat), 32'd3);
    rd = rdata;
    e  = err;
    @(posedge clk); #1;
  endtask

  task automatic txn0(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output int lat);
    @(negedge clk);
    req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    @(posedge clk); #1;
    lat = 0;
    while (!ack0 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    req0 = 1'b0;
    rd = rdata0;
    @(posedge clk); #1;
  endtask

  task automatic load_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic        e;
    int          lat;
    txn(1'b0, a, 32'd0, rd, e, lat);
    check({tag, "_data"}, rd, exp);
    check({tag, "_err"}, 32'(e), 32'd0);
  endtask

  task automatic store_chk(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic exp_err);
    logic [31:0] rd;
    logic        e;
    int          lat;
    txn(1'b1, a, d, rd, e, lat);
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_err"}, 32'(e), 32'(exp_err));
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    logic [9:0]  ackv, busyv;

    rst_n = 1'b1;
    req = 0; we = 0; addr = 0; wdata = 0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;

    // Asynchronous reset mid-cycle
    #3 rst_n = 1'b0;
    #1;
    check("rst_rdata", rdata, 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    load_chk("load0_after_rst", 32'd0, 32'h0000_0000);

    // Store timing: ack only after E3, busy E0..E4
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'd8; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      ackv[k]  = ack;
      busyv[k] = busy;
      if (k == 3) req = 1'b0;
      if (k < 4) begin
        @(posedge clk); #1;
      end
    end
    check("store8_ack_pattern", 32'(ackv[4:0]), 32'h08);
    check("store8_busy_pattern", 32'(busyv[4:0]), 32'h0F);

    load_chk("load8", 32'd8, 32'h1234_5678);

    // Misaligned load keeps the previous rdata
    txn(1'b0, 32'd9, 32'd0, rd, e, lat);
    check("misload9_err", 32'(e), 32'd1);
    check("misload9_rdata_held", rd, 32'h1234_5678);

    // Wrap and upper-bit masking
    store_chk("store28", 32'd28, 32'hAABB_CCDD, 1'b0);
    store_chk("store0", 32'd0, 32'h1122_3344, 1'b0);
    load_chk("load28", 32'd28, 32'hAABB_CCDD);
    load_chk("load_ffffffe0", 32'hFFFF_FFE0, 32'h1122_3344);

    // Misaligned store leaves memory untouched
    store_chk("misstore6", 32'd6, 32'hFFFF_FFFF, 1'b1);
    load_chk("load4_after_mis", 32'd4, 32'h0000_0000);
    load_chk("load8_after_mis", 32'd8, 32'h1234_5678);

    // Inputs changed and req dropped during WAIT
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'd12; wdata = 32'h5566_7788;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; addr = 32'd16; wdata = 32'h0;
    lat = 1;
    while (!ack && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("abuse_lat", 32'(lat), 32'd3);
    @(posedge clk); #1;
    load_chk("abuse_load12", 32'd12, 32'h5566_7788);
    load_chk("abuse_load16", 32'd16, 32'h0000_0000);

    // req held through RESP: second acceptance at E5, ack after E8
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'd28;
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      ackv[k]  = ack;
      busyv[k] = busy;
      if (k == 8) req = 1'b0;
      if (k < 9) begin
        @(posedge clk); #1;
      end
    end
    check("held_ack_pattern", 32'(ackv), 32'h108);
    check("held_busy_pattern", 32'(busyv), 32'h1EF);
    check("held_rdata", rdata, 32'hAABB_CCDD);

    // Zero wait states
    txn0(1'b1, 32'd4, 32'hCAFE_BABE, rd, lat);
    check("w0_store_lat", 32'(lat), 32'd1);
    txn0(1'b0, 32'd4, 32'd0, rd, lat);
    check("w0_load_lat", 32'(lat), 32'd1);
    check("w0_load_data", rd, 32'hCAFE_BABE);

    // Reset during WAIT discards the store and clears memory
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'd20; wdata = 32'h9999_9999;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    req = 1'b0;
    lat = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (ack) lat++;
      if (k == 1) rst_n = 1'b1;
    end
    check("midrst_no_ack", 32'(lat), 32'd0);
    load_chk("midrst_load20", 32'd20, 32'h0000_0000);
    load_chk("midrst_load8", 32'd8, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
